siso_shift_hold: RTL and testbench

SISO_SHIFT_HOLD -- requirements
Module: siso_shift_hold

---
 rtl/siso_pkg.sv | 14 +
 rtl/siso_lane.sv | 24 ++
 rtl/siso_shift_hold.sv | 106 ++++++++++
 tb/tb_siso_shift_hold.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared definitions for the SISO shift-and-hold block: FSM state encoding.
package siso_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'b00;
    localparam logic [1:0] ENC_SHIFT = 2'b01;
    localparam logic [1:0] ENC_HOLD  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SHIFT = ENC_SHIFT,
        ST_HOLD  = ENC_HOLD
    } state_t;

endpackage

// File: rtl/siso_lane.sv
// One serial lane: DEPTH-stage shift register, stage 0 takes the serial input.
module siso_lane #(
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [DEPTH-1:0] o_q
);

    logic [DEPTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_shift) begin
            r_q <= {r_q[DEPTH-2:0], i_sin};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/siso_shift_hold.sv
// Burst-controlled multi-lane SISO shifter that freezes its contents after each burst.
// Optional parallel stage view enabled by macro SISO_PAR_OUT_EN.
module siso_shift_hold
    import siso_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LANES = 1,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             en,
    input  logic [LANES-1:0] din,
    output logic [LANES-1:0] dout,
    output logic             busy,
    output logic             done
`ifdef SISO_PAR_OUT_EN
    ,
    output logic [LANES*DEPTH-1:0] pout
`endif
);

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_shift;
    logic [DEPTH-1:0] w_q [LANES];

    // A start cycle only reloads the count; shifting resumes on the following cycle.
    assign w_shift = (r_state == ST_SHIFT) && en && !start && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_cnt   <= len;
                r_state <= ST_SHIFT;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_HOLD;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (en) begin
                            r_cnt <= r_cnt - CNT_ONE;
                            if (r_cnt == CNT_ONE) begin
                                r_state <= ST_HOLD;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            siso_lane #(
                .DEPTH(DEPTH)
            ) u_lane (
                .i_clk  (clk),
                .i_clr  (rst),
                .i_shift(w_shift),
                .i_sin  (din[g]),
                .o_q    (w_q[g])
            );
        end
    endgenerate

    always_comb begin
        dout = '0;
        for (int l = 0; l < LANES; l++) begin
            dout[l] = w_q[l][DEPTH-1];
        end
    end

`ifdef SISO_PAR_OUT_EN
    always_comb begin
        pout = '0;
        for (int l = 0; l < LANES; l++) begin
            pout[l*DEPTH +: DEPTH] = w_q[l];
        end
    end
`endif

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_siso_shift_hold.sv
// Scoreboard bench for siso_shift_hold (DEPTH=4, LANES=1, LEN_W=4).
module tb_siso_shift_hold;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       en;
    logic [0:0] din;
    logic [0:0] dout;
    logic       busy;
    logic       done;
`ifdef SISO_PAR_OUT_EN
    logic [3:0] pout;
`endif

    typedef struct {
        logic       dout;
        logic [3:0] pout;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    siso_shift_hold #(
        .DEPTH(4),
        .LANES(1),
        .LEN_W(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .len  (len),
        .en   (en),
        .din  (din),
        .dout (dout),
        .busy (busy),
        .done (done)
`ifdef SISO_PAR_OUT_EN
        ,
        .pout (pout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding burst expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL done_unexpected: got done=1 expected no pulse");
            end else begin
                e = sb.pop_front();
                chk("sb_dout", 32'(dout), 32'(e.dout));
`ifdef SISO_PAR_OUT_EN
                chk("sb_pout", 32'(pout), 32'(e.pout));
`endif
                chk("sb_busy", 32'(busy), 32'd0);
            end
        end
    end

    logic seq1 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic en3  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic din3 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int bcnt;
        rst = 1'b1; start = 1'b0; len = 4'd0; en = 1'b0; din = 1'b0;
        tick(); tick();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef SISO_PAR_OUT_EN
        chk("rst_pout", 32'(pout), 32'd0);
`endif
        rst = 1'b0; en = 1'b1; din = 1'b1;
        tick(); tick(); tick();
        chk("idle_frozen_dout", 32'(dout), 32'd0);
`ifdef SISO_PAR_OUT_EN
        chk("idle_frozen_pout", 32'(pout), 32'd0);
`endif

        // Burst of 4 with din 1,1,0,1
        sb.push_back('{1'b1, 4'b1101});
        start = 1'b1; len = 4'd4; en = 1'b1; din = 1'b0;
        tick();
        start = 1'b0;
        chk("s1_busy_start", 32'(busy), 32'd1);
`ifdef SISO_PAR_OUT_EN
        chk("s1_no_shift_on_start", 32'(pout), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            din = seq1[i];
            tick();
        end
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_busy_end", 32'(busy), 32'd0);

        // Hold: contents frozen whatever din/en do
        for (int i = 0; i < 10; i++) begin
            din = 1'(i);
            en  = 1'(i >> 1);
            tick();
        end
        chk("hold_dout", 32'(dout), 32'd1);
`ifdef SISO_PAR_OUT_EN
        chk("hold_pout", 32'(pout), 32'hD);
`endif

        // Burst of 6 with two stall cycles
        sb.push_back('{1'b1, 4'b1001});
        start = 1'b1; len = 4'd6; en = 1'b1; din = 1'b1;
        tick();
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            en  = en3[i];
            din = din3[i];
            tick();
            if (busy) bcnt++;
        end
        en = 1'b1;
        tick(); if (busy) bcnt++;
        tick(); if (busy) bcnt++;
        chk("s3_busy_cycles", 32'(bcnt), 32'd8);

        // Restart after two shifts of a len=5 burst
        sb.push_back('{1'b0, 4'b0110});
        start = 1'b1; len = 4'd5; en = 1'b1; din = 1'b0;
        tick();
        start = 1'b0;
        din = 1'b1; tick();
        din = 1'b0; tick();
        start = 1'b1; len = 4'd3; din = 1'b1;
        tick();
        start = 1'b0;
        chk("s4_busy_restart", 32'(busy), 32'd1);
        din = 1'b1; tick();
        din = 1'b1; tick();
        din = 1'b0; tick();
        chk("s4_done", 32'(done), 32'd1);
        tick();

        // Zero-length burst
        sb.push_back('{1'b0, 4'b0110});
        start = 1'b1; len = 4'd0; en = 1'b1; din = 1'b1;
        tick();
        start = 1'b0;
        chk("s5_done_early", 32'(done), 32'd0);
        chk("s5_busy", 32'(busy), 32'd1);
        tick();
        chk("s5_done", 32'(done), 32'd1);
        tick();

        // Reset mid-burst aborts without done
        start = 1'b1; len = 4'd4; en = 1'b1; din = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
`ifdef SISO_PAR_OUT_EN
        chk("abort_pout", 32'(pout), 32'd0);
`endif
        tick(); tick(); tick();
        chk("abort_idle_dout", 32'(dout), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
